// File: rtl/plic_apb_arb_pkg.sv
// Shared types and constants for the PLIC APB front-end arbiter.
package plic_apb_arb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    // Read data returned to the master when a transfer is forced to end by the timeout.
    localparam logic [APB_DW-1:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/plic_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after ptr_i,
// wrapping modulo NMST.
module plic_rr_pick #(
    parameter int NMST = 2,
    parameter int IW   = (NMST > 1) ? $clog2(NMST) : 1
) (
    input  logic [NMST-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            vld_o,
    output logic [IW-1:0]   idx_o
);

    int j;

    // Scanning from the farthest offset down lets the nearest hit overwrite the others.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int i = NMST - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= NMST) begin
                j = j - NMST;
            end
            if (req_i[j]) begin
                vld_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/plic_apb_arbiter.sv
// Round-robin arbiter letting NMST APB masters share the PLIC's single APB slave port,
// with a bounded ACCESS phase so a hung slave cannot lock out the other masters.
module plic_apb_arbiter
    import plic_apb_arb_pkg::*;
#(
    parameter int NMST    = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NMST-1:0]             m_psel,
    input  logic [NMST-1:0]             m_penable,
    input  logic [NMST-1:0]             m_pwrite,
    input  logic [NMST-1:0][APB_AW-1:0] m_paddr,
    input  logic [NMST-1:0][APB_DW-1:0] m_pwdata,
    output logic [APB_DW-1:0]           m_prdata,
    output logic [NMST-1:0]             m_pready,
    output logic [NMST-1:0]             m_pslverr,
    output logic                        plic_psel,
    output logic                        plic_penable,
    output logic                        plic_pwrite,
    output logic [APB_AW-1:0]           plic_paddr,
    output logic [APB_DW-1:0]           plic_pwdata,
    input  logic [APB_DW-1:0]           plic_prdata,
    input  logic                        plic_pready,
    input  logic                        plic_pslverr,
    output arb_state_e                  dbg_state_o
);

    // Handshake: a master request is m_psel; its response is valid only in the cycle its
    // own m_pready bit is 1, and m_prdata/m_pslverr are qualified by that bit. Downstream
    // follows plain APB: SETUP (psel, !penable) then ACCESS (psel, penable) until pready.

    localparam int IW = $clog2(NMST);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NMST - 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [APB_AW-1:0] addr_q, addr_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic              in_access;
    logic              timeout_hit;
    logic              done;
    logic              resp_vld;
    logic [IW-1:0]     next_ptr;

    plic_rr_pick #(
        .NMST (NMST),
        .IW   (IW)
    ) u_pick (
        .req_i (m_psel),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign in_access   = (state_q == ARB_ACCESS);
    // A real pready in the timeout cycle wins over the forced error.
    assign timeout_hit = (TIMEOUT != 0) && in_access && (cnt_q == CNT_LAST) && !plic_pready;
    assign done        = in_access && (plic_pready || timeout_hit);
    // If the owner has abandoned its request, the downstream transfer ends but is not reported.
    assign resp_vld    = done && m_psel[gnt_q];
    assign next_ptr    = (gnt_q == LAST_IDX) ? '0 : gnt_q + IW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    addr_d  = m_paddr[pick_idx];
                    wdata_d = m_pwdata[pick_idx];
                    wr_d    = m_pwrite[pick_idx];
                    state_d = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                cnt_d   = '0;
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (done) begin
                    ptr_d   = next_ptr;
                    state_d = ARB_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        plic_psel    = (state_q != ARB_IDLE);
        plic_penable = in_access;
        plic_pwrite  = wr_q;
        plic_paddr   = addr_q;
        plic_pwdata  = wdata_q;
        m_pready     = '0;
        m_pslverr    = '0;
        m_prdata     = '0;
        if (resp_vld) begin
            m_pready[gnt_q]  = 1'b1;
            m_pslverr[gnt_q] = plic_pready ? plic_pslverr : 1'b1;
            m_prdata         = plic_pready ? plic_prdata : ARB_ERR_RDATA;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: doc/plic_apb_arbiter.md
# plic_apb_arbiter

Round-robin APB arbiter that lets NMST independent APB masters share the single APB slave port of the PLIC wrapper. Typical masters are the host-side CSR bridge and a debug/monitor unit. The block sits directly in front of the PLIC's `plic_p*` port. It serialises transfers and latches the winning master's request, and it guarantees completion with a bounded-latency timeout, so a hung slave cannot lock out other masters.

## Interface
Parameters:
- `NMST`, 2: number of upstream APB masters (2..8).
- `TIMEOUT`, 256: maximum ACCESS cycles before forced error completion; 0 disables the timeout.

Ports (clock and reset first):
- `clk`  in  1  single clock for all logic.
- `rstn`  in  1  reset, asynchronous assertion, active-low.
- `m_psel`  in  NMST  per-master select.
- `m_penable`  in  NMST  per-master enable.
- `m_pwrite`  in  NMST  per-master write flag.
- `m_paddr`  in  NMST x 32  per-master address.
- `m_pwdata`  in  NMST x 32  per-master write data.
- `m_prdata`  out  32  read data, broadcast to all masters; meaningful only with the owner's `m_pready`.
- `m_pready`  out  NMST  per-master ready; only the granted master's bit can be 1.
- `m_pslverr`  out  NMST  per-master error, qualified by `m_pready`.
- `plic_psel`, `plic_penable`, `plic_pwrite`  out  1 each  downstream APB controls.
- `plic_paddr`, `plic_pwdata`  out  32 each  downstream address and write data.
- `plic_prdata`  in  32  downstream read data.
- `plic_pready`, `plic_pslverr`  in  1 each  downstream response.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - Requesters are `m_psel`.
  - If any requester is present, pick the first index at or after `rr_ptr`, wrapping modulo NMST.
  - Register `gnt_idx` and latch that master's addr, write and wdata. Go to SETUP.
- **SETUP**
  - `plic_psel`=1, `plic_penable`=0, address and data driven from the latches.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - `plic_psel`=1, `plic_penable`=1; the timeout counter increments each cycle.
  - On `plic_pready`=1:
    - `m_pready[gnt_idx]`=1 (combinational pass-through).
    - `m_pslverr[gnt_idx]`=`plic_pslverr`.
    - `m_prdata`=`plic_prdata`.
    - Set `rr_ptr`=(`gnt_idx`+1) mod NMST and go to IDLE.
  - On timeout (TIMEOUT≠0 and counter = TIMEOUT-1 without ready):
    - `m_pready[gnt_idx]`=1 and `m_pslverr[gnt_idx]`=1; `m_prdata`=32'hDEAD_BEEF.
    - Drop `plic_psel` next cycle, update `rr_ptr`, go to IDLE.
- **Boundary conditions**
  - Non-granted masters see `m_pready`=0 and wait. The APB protocol already requires them to hold their request stable.
  - If the granted master drops `m_psel` mid-transfer (protocol violation), the downstream transfer still completes and the response is discarded.
  - `plic_pready` arriving in the same cycle as the timeout takes priority: the real response wins.
  - `plic_pready` is ignored outside ACCESS.
  - With a single requester, that requester is re-granted after the IDLE bubble regardless of `rr_ptr`.
  - `rr_ptr` wraps from NMST-1 to 0.
- **Reset**
  - Reset at any time (including mid-ACCESS) returns to IDLE.
  - Reset values: `rr_ptr`=0, counter=0, all `plic_*` outputs 0, `m_pready`=0, `m_pslverr`=0, `m_prdata`=0.

## Timing
- Grant decision is registered at the IDLE cycle edge. SETUP is the next cycle and ACCESS the one after.
- Minimum latency from `m_psel` rising (IDLE) to `m_pready`: 2 cycles with a zero-wait slave. A slave with k wait states adds k cycles.
- Each transfer is followed by one mandatory IDLE cycle, so back-to-back throughput is one transfer per 3 cycles minimum.
- Worst-case wait for a requester is (NMST-1) x (TIMEOUT+2) cycles plus its own transfer.
- Timeout counter width is clog2(TIMEOUT+1) and saturates. It clears on every SETUP.

## Structure
- Package `plic_apb_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE/SETUP/ACCESS);
  - `APB_AW`=32 and `APB_DW`=32;
  - the timeout read-data constant `ARB_ERR_RDATA`=32'hDEAD_BEEF.
- One sub-module: `plic_rr_pick`. It is a combinational NMST-wide round-robin picker: inputs are the request vector and pointer; outputs are the valid flag and index.

## Test plan
- Master 0 reads 0x0C00_0004 and the slave returns 32'h7 with no wait states → `m_pready[0]` is asserted 2 cycles after `m_psel[0]`, `m_prdata`=7, `m_pslverr`=0.
- Masters 0 and 1 request simultaneously from reset → master 0 is served first and master 1 next (after the IDLE bubble). If both re-request, master 0 goes next (`rr_ptr` wrapped to 0).
- Slave inserts 3 wait states on a write of 32'h1 to 0x0C20_0000 → `plic_penable` stays high 4 cycles, and `m_pready` rises in the 4th ACCESS cycle.
- TIMEOUT=8 and the slave never asserts ready → on the 8th ACCESS cycle, `m_pready`=1, `m_pslverr`=1, `m_prdata`=DEADBEEF; `plic_psel`=0 the next cycle.
- Slave returns `pslverr`=1 with ready → only the granted master sees the error, and other masters' `m_pready` stays 0.
- `rstn` is asserted during ACCESS → all outputs are 0 immediately. After release, a pending request from master 1 is granted on the first IDLE cycle.
